mc_bus_bridge: RTL

Bridge between the MCU's asynchronous SRAM-style parallel bus (mc_ce/mc_we/mc_oe, mc_add, mc_data) and the FPGA's synchronous register space. It sits directly upstream of the Bus Pirate register file, command FIFO and state-machine control registers inside `top`. It synchronises the strobes into `clock`, emits exactly one single-cycle register write or read per MCU access, and drives read data back onto mc_data. It also flags protocol violations.

---
 rtl/mc_bridge_pkg.sv | 17 +
 rtl/mc_sync.sv | 25 ++
 rtl/mc_bus_bridge.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mc_bridge_pkg.sv
// Shared types and constants for the MCU parallel-bus bridge.
package mc_bridge_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_WR        = 3'd1;
    localparam state_t ST_RD        = 3'd2;
    localparam state_t ST_RD_LATCH  = 3'd3;
    localparam state_t ST_RD_HOLD   = 3'd4;
    localparam state_t ST_WAIT_IDLE = 3'd5;

    localparam int SYNC_DEPTH    = 2;
    localparam int MIN_STROBE_LO = 1;
    localparam int MIN_STROBE_HI = 15;

endpackage

// File: rtl/mc_sync.sv
// Multi-flop synchroniser for an asynchronous active-low strobe; resets to the inactive (high) level.
module mc_sync
    import mc_bridge_pkg::*;
#(
    parameter int DEPTH = SYNC_DEPTH
) (
    input  logic clock,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic [DEPTH-1:0] r_ff;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ff <= '1;
        end else begin
            r_ff <= {r_ff[DEPTH-2:0], i_d};
        end
    end

    assign o_q = r_ff[DEPTH-1];

endmodule

// File: rtl/mc_bus_bridge.sv
// MCU async SRAM-style bus to single-cycle register read/write pulses, with read-back drive.
// Build macro MC_BUS_GLITCH_FILTER_EN adds a MIN_STROBE-cycle low-time filter on strobe acceptance.
module mc_bus_bridge
    import mc_bridge_pkg::*;
#(
    parameter int MC_DATA_WIDTH = 16,
    parameter int MC_ADD_WIDTH  = 6,
    parameter int MIN_STROBE    = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     mc_ce,
    input  logic                     mc_we,
    input  logic                     mc_oe,
    input  logic [MC_ADD_WIDTH-1:0]  mc_add,
    inout  wire  [MC_DATA_WIDTH-1:0] mc_data,
    output logic [MC_ADD_WIDTH-1:0]  reg_add,
    output logic [MC_DATA_WIDTH-1:0] reg_wdata,
    output logic                     reg_wr,
    output logic                     reg_rd,
    input  logic [MC_DATA_WIDTH-1:0] reg_rdata,
    output logic                     bus_err,
    output state_t                   dbg_state
);

    if (MIN_STROBE < MIN_STROBE_LO || MIN_STROBE > MIN_STROBE_HI) begin : g_bad_min_strobe
        $error("MIN_STROBE out of range");
    end

    logic w_ce_s, w_we_s, w_oe_s;
    logic w_low, w_accept, w_err_set;
    state_t w_state_nxt;
    state_t r_state;
    logic [1:0] r_flush;
    logic [MC_ADD_WIDTH-1:0]  r_reg_add;
    logic [MC_DATA_WIDTH-1:0] r_reg_wdata;
    logic [MC_DATA_WIDTH-1:0] r_rd_buf;
    logic r_bus_err;

    mc_sync u_sync_ce (.clock(clock), .reset(reset), .i_d(mc_ce), .o_q(w_ce_s));
    mc_sync u_sync_we (.clock(clock), .reset(reset), .i_d(mc_we), .o_q(w_we_s));
    mc_sync u_sync_oe (.clock(clock), .reset(reset), .i_d(mc_oe), .o_q(w_oe_s));

    assign w_low = !w_ce_s && (!w_we_s || !w_oe_s);

`ifdef MC_BUS_GLITCH_FILTER_EN
    logic [3:0] r_lo_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_lo_cnt <= 4'd0;
        end else if (r_state != ST_IDLE || !w_low) begin
            r_lo_cnt <= 4'd0;
        end else if (r_lo_cnt != 4'hF) begin
            r_lo_cnt <= r_lo_cnt + 4'd1;
        end
    end

    assign w_accept = w_low && (r_lo_cnt >= 4'(MIN_STROBE - 1));
`else
    assign w_accept = w_low;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_err_set   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (!w_we_s && !w_oe_s) begin
                        w_err_set   = 1'b1;
                        w_state_nxt = ST_WAIT_IDLE;
                    end else if (!w_we_s) begin
                        w_state_nxt = ST_WR;
                    end else begin
                        w_state_nxt = ST_RD;
                    end
                end
            end
            ST_WR:       w_state_nxt = ST_WAIT_IDLE;
            ST_RD:       w_state_nxt = ST_RD_LATCH;
            ST_RD_LATCH: w_state_nxt = ST_RD_HOLD;
            ST_RD_HOLD: begin
                // A write strobe overlapping the read is flagged and never turned into a pulse.
                if (!w_we_s && !w_ce_s) w_err_set = 1'b1;
                if (w_oe_s || w_ce_s) w_state_nxt = w_we_s ? ST_IDLE : ST_WAIT_IDLE;
            end
            ST_WAIT_IDLE: begin
                if (w_we_s && w_oe_s && r_flush == 2'd0) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_WAIT_IDLE;
        endcase
    end

    // After reset the synchronisers show a forced high; r_flush waits until real pin levels arrive.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_WAIT_IDLE;
            r_flush     <= 2'(SYNC_DEPTH);
            r_reg_add   <= '0;
            r_reg_wdata <= '0;
            r_rd_buf    <= '0;
            r_bus_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_flush != 2'd0) r_flush <= r_flush - 2'd1;
            if (r_state == ST_IDLE && (w_state_nxt == ST_WR || w_state_nxt == ST_RD)) begin
                r_reg_add <= mc_add;
            end
            if (r_state == ST_IDLE && w_state_nxt == ST_WR) r_reg_wdata <= mc_data;
            if (r_state == ST_RD_LATCH) r_rd_buf <= reg_rdata;
            if (w_err_set) r_bus_err <= 1'b1;
        end
    end

    assign reg_add   = r_reg_add;
    assign reg_wdata = r_reg_wdata;
    assign reg_wr    = (r_state == ST_WR);
    assign reg_rd    = (r_state == ST_RD);
    assign bus_err   = r_bus_err;
    assign dbg_state = r_state;

    // Raw pins gate the driver so the bus releases without waiting for the synchronisers.
    assign mc_data = (r_state == ST_RD_HOLD && !mc_oe && !mc_ce) ? r_rd_buf : 'z;

endmodule
